uart_rx_frame_chk: RTL and testbench

//  Parametrised UART RX frame checker; successor to the single-bit start-glitch check.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_par_calc.sv | 16 +
 rtl/uart_rx_frame_chk.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_frame_chk.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame checker and its parity helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

endpackage

// File: rtl/uart_rx_par_calc.sv
// Combinational parity bit for a DATA_W-bit word; shared with the TX serialiser.
module uart_rx_par_calc
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              par_typ_i,
    output logic              par_bit_o
);

    always_comb begin
        par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);
    end

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker: validates start/data/parity/stop bits and deserialises LSB-first.
// Optional saturating error counters are enabled with the UART_RX_ERR_CNT_EN macro.
module uart_rx_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_det,
    input  logic              bit_vld,
    input  logic              sampled_bit,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              stop_two,
`ifdef UART_RX_ERR_CNT_EN
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  glitch_cnt,
    output logic [CNT_W-1:0]  par_cnt,
    output logic [CNT_W-1:0]  stp_cnt,
`endif
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              strt_glitch,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              stop_two_q, stop_two_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_fail_q, par_fail_d;
    logic              data_valid_q, data_valid_d;
    logic              strt_glitch_q, strt_glitch_d;
    logic              par_err_q, par_err_d;
    logic              stp_err_q, stp_err_d;
    logic              par_bit;

    uart_rx_par_calc #(
        .DATA_W (DATA_W)
    ) u_par_calc (
        .data_i    (shreg_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        p_data_d      = p_data_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        stop_two_d    = stop_two_q;
        stop_cnt_d    = stop_cnt_q;
        par_fail_d    = par_fail_q;
        data_valid_d  = 1'b0;
        strt_glitch_d = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A bit_vld coinciding with start_det is dropped here on purpose.
                if (start_det) begin
                    state_d    = StStart;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    stop_two_d = stop_two;
                    stop_cnt_d = 1'b0;
                    par_fail_d = 1'b0;
                end
            end
            StStart: begin
                if (bit_vld) begin
                    if (sampled_bit) begin
                        strt_glitch_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (bit_vld) begin
                    shreg_d = {sampled_bit, shreg_q[DATA_W-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_vld) begin
                    if (sampled_bit != par_bit) begin
                        par_err_d  = 1'b1;
                        par_fail_d = 1'b1;
                    end
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_vld) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                        state_d   = StIdle;
                    end else if (stop_two_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        if (!par_fail_q) begin
                            data_valid_d = 1'b1;
                            p_data_d     = shreg_q;
                        end
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            p_data_q      <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            stop_two_q    <= 1'b0;
            stop_cnt_q    <= 1'b0;
            par_fail_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            p_data_q      <= p_data_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            stop_two_q    <= stop_two_d;
            stop_cnt_q    <= stop_cnt_d;
            par_fail_q    <= par_fail_d;
            data_valid_q  <= data_valid_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign p_data      = p_data_q;
    assign data_valid  = data_valid_q;
    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = (state_q != StIdle);

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0] stp_cnt_q, stp_cnt_d;

    // Counters step alongside their pulse register; a clear overrides a same-cycle error.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        par_cnt_d    = par_cnt_q;
        stp_cnt_d    = stp_cnt_q;
        if (clr_cnt) begin
            glitch_cnt_d = '0;
            par_cnt_d    = '0;
            stp_cnt_d    = '0;
        end else begin
            if (strt_glitch_d && (glitch_cnt_q != '1)) glitch_cnt_d = glitch_cnt_q + 1'b1;
            if (par_err_d && (par_cnt_q != '1))        par_cnt_d    = par_cnt_q + 1'b1;
            if (stp_err_d && (stp_cnt_q != '1))        stp_cnt_d    = stp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            glitch_cnt_q <= '0;
            par_cnt_q    <= '0;
            stp_cnt_q    <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
            par_cnt_q    <= par_cnt_d;
            stp_cnt_q    <= stp_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
    assign par_cnt    = par_cnt_q;
    assign stp_cnt    = stp_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Directed self-checking bench for uart_rx_frame_chk (DATA_W=8); counter checks need UART_RX_ERR_CNT_EN.
module tb_uart_rx_frame_chk;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start_det, bit_vld, sampled_bit;
    logic       par_en, par_typ, stop_two;
    logic [7:0] p_data;
    logic       data_valid, strt_glitch, par_err, stp_err, busy;
`ifdef UART_RX_ERR_CNT_EN
    logic       clr_cnt;
    logic [1:0] glitch_cnt, par_cnt, stp_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    uart_rx_frame_chk #(
        .DATA_W (8),
`ifdef UART_RX_ERR_CNT_EN
        .CNT_W  (2)
`else
        .CNT_W  (8)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_det   (start_det),
        .bit_vld     (bit_vld),
        .sampled_bit (sampled_bit),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .stop_two    (stop_two),
`ifdef UART_RX_ERR_CNT_EN
        .clr_cnt     (clr_cnt),
        .glitch_cnt  (glitch_cnt),
        .par_cnt     (par_cnt),
        .stp_cnt     (stp_cnt),
`endif
        .p_data      (p_data),
        .data_valid  (data_valid),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one sampled bit for one cycle; returns 1 time unit after the consuming edge.
    task automatic send_bit(input logic b);
        bit_vld     = 1'b1;
        sampled_bit = b;
        tick();
        bit_vld     = 1'b0;
    endtask

    task automatic do_start();
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    initial begin
        RST = 1'b1;
        start_det = 1'b0; bit_vld = 1'b0; sampled_bit = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; stop_two = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
        clr_cnt = 1'b0;
`endif
        tick(); tick();
        check("rst_p_data", 32'(p_data), 32'h00);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_strt_glitch", 32'(strt_glitch), 0);
        check("rst_par_err", 32'(par_err), 0);
        check("rst_stp_err", 32'(stp_err), 0);
        check("rst_busy", 32'(busy), 0);
        RST = 1'b0;
        tick();

        // bit_vld while idle must not start anything
        send_bit(1'b0);
        check("idle_bitvld_busy", 32'(busy), 0);

        // Plain 8N1 frame 0xA5
        do_start();
        check("t1_busy", 32'(busy), 1);
        send_bit(1'b0);
        send_data(8'hA5);
        check("t1_no_early_dv", 32'(data_valid), 0);
        send_bit(1'b1);
        check("t1_data_valid", 32'(data_valid), 1);
        check("t1_p_data", 32'(p_data), 32'hA5);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_no_stp_err", 32'(stp_err), 0);
        tick();
        check("t1_dv_one_cycle", 32'(data_valid), 0);

        // Start glitch
        do_start();
        send_bit(1'b1);
        check("t2_strt_glitch", 32'(strt_glitch), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_no_dv", 32'(data_valid), 0);
        check("t2_p_data_held", 32'(p_data), 32'hA5);
        tick();
        check("t2_glitch_one_cycle", 32'(strt_glitch), 0);

        // Even parity, data 0x03 (expected parity 0), send 1; config changed mid-frame
        par_en = 1'b1; par_typ = 1'b0;
        do_start();
        par_en = 1'b0;
        send_bit(1'b0);
        send_data(8'h03);
        send_bit(1'b1);
        check("t3_par_err", 32'(par_err), 1);
        check("t3_busy_after_par", 32'(busy), 1);
        send_bit(1'b1);
        check("t3_no_dv", 32'(data_valid), 0);
        check("t3_par_err_cleared", 32'(par_err), 0);
        check("t3_busy_done", 32'(busy), 0);
        check("t3_p_data_held", 32'(p_data), 32'hA5);

        // Odd parity, data 0x07 (expected parity 0), good frame
        par_en = 1'b1; par_typ = 1'b1;
        do_start();
        par_en = 1'b0; par_typ = 1'b0;
        send_bit(1'b0);
        send_data(8'h07);
        send_bit(1'b0);
        check("t3b_no_par_err", 32'(par_err), 0);
        send_bit(1'b1);
        check("t3b_data_valid", 32'(data_valid), 1);
        check("t3b_p_data", 32'(p_data), 32'h07);

        // Two stop bits, second sampled 0
        stop_two = 1'b1;
        do_start();
        stop_two = 1'b0;
        send_bit(1'b0);
        send_data(8'h5A);
        send_bit(1'b1);
        check("t4_first_stop_no_dv", 32'(data_valid), 0);
        check("t4_first_stop_busy", 32'(busy), 1);
        send_bit(1'b0);
        check("t4_stp_err", 32'(stp_err), 1);
        check("t4_no_dv", 32'(data_valid), 0);
        check("t4_busy_done", 32'(busy), 0);
        check("t4_p_data_held", 32'(p_data), 32'h07);

        // Two stop bits, both good
        stop_two = 1'b1;
        do_start();
        send_bit(1'b0);
        send_data(8'hC3);
        send_bit(1'b1);
        check("t4b_first_stop_no_dv", 32'(data_valid), 0);
        send_bit(1'b1);
        check("t4b_data_valid", 32'(data_valid), 1);
        check("t4b_p_data", 32'(p_data), 32'hC3);
        stop_two = 1'b0;

        // Reset mid-frame, then a clean 0x3C frame
        do_start();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_p_data", 32'(p_data), 32'h00);
        check("t5_rst_pulses", 32'({data_valid, strt_glitch, par_err, stp_err}), 0);
        do_start();
        send_bit(1'b0);
        send_data(8'h3C);
        send_bit(1'b1);
        check("t5_data_valid", 32'(data_valid), 1);
        check("t5_p_data", 32'(p_data), 32'h3C);

        // start_det and bit_vld together in idle: the bit is dropped
        start_det = 1'b1; bit_vld = 1'b1; sampled_bit = 1'b1;
        tick();
        start_det = 1'b0; bit_vld = 1'b0;
        check("t7_busy", 32'(busy), 1);
        check("t7_no_glitch", 32'(strt_glitch), 0);
        send_bit(1'b0);
        send_data(8'h81);
        send_bit(1'b1);
        check("t7_p_data", 32'(p_data), 32'h81);

`ifdef UART_RX_ERR_CNT_EN
        for (int i = 0; i < 5; i++) begin
            do_start();
            send_bit(1'b1);
        end
        check("t6_glitch_sat", 32'(glitch_cnt), 3);
        check("t6_par_cnt", 32'(par_cnt), 0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t6_glitch_clr", 32'(glitch_cnt), 0);
        do_start();
        clr_cnt = 1'b1;
        send_bit(1'b1);
        clr_cnt = 1'b0;
        check("t6_clr_wins", 32'(glitch_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
